// File: rtl/reg_file_write_arbiter.sv
// Two-requester round-robin arbiter for the single Register_File write port.
// Grants are combinational (valid/ready handshake). The accepted write is
// registered once and drives RegWrite/write_addr/write_data directly. A
// saturating counter records cycles in which both requesters competed.
module reg_file_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  stall,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  grant_id,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Requester that wins a tie: 0 or 1. Flips to the other side after a transfer.
  logic prio;
  logic grant0;
  logic grant1;
  logic contention;

  // Round-robin grant; nothing is granted while stalled or held in reset.
  always_comb begin
    // NOTE: both grants get a default before any branch, so every path
    // assigns them and no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !stall) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~prio;
        grant1 = prio;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign contention = req0_valid && req1_valid && !stall;

  // Priority pointer: the requester that just transferred yields the next tie.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      prio <= 1'b0;
    end else if (grant0) begin
      prio <= 1'b1;
    end else if (grant1) begin
      prio <= 1'b0;
    end
  end

  // Output stage: one-cycle registered copy of the accepted write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      grant_id   <= 1'b0;
    end else begin
      RegWrite <= grant0 | grant1;
      if (grant0) begin
        write_addr <= req0_addr;
        write_data <= req0_data;
        grant_id   <= 1'b0;
      end else if (grant1) begin
        write_addr <= req1_addr;
        write_data <= req1_data;
        grant_id   <= 1'b1;
      end
    end
  end

  // Saturating count of cycles where both requesters competed outside a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_count <= '0;
    end else if (contention && (conflict_count != CNT_MAX)) begin
      conflict_count <= conflict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Self-checking bench for reg_file_write_arbiter: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a behavioural model of the arbitration rules.
module tb_reg_file_write_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [2:0] req0_addr = '0;
  logic [7:0] req0_data = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [2:0] req1_addr = '0;
  logic [7:0] req1_data = '0;
  logic       req1_ready;
  logic       stall = 1'b0;
  logic       RegWrite;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic       grant_id;
  logic [7:0] conflict_count;

  int total = 0;
  int bad = 0;

  reg_file_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .stall(stall), .RegWrite(RegWrite), .write_addr(write_addr),
    .write_data(write_data), .grant_id(grant_id), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // Register_File stand-in fed by the arbiter outputs.
  logic [7:0] rf [8];
  always @(posedge clk) if (RegWrite) rf[write_addr] <= write_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_prio: which requester wins when both are valid.
  int         m_prio = 0;
  logic       m_we = 1'b0;
  logic [2:0] m_addr = '0;
  logic [7:0] m_data = '0;
  int         m_id = 0;
  int         m_cnt = 0;

  // Who is accepted right now: -1 for nobody.
  function automatic int model_grant();
    if (reset || stall) return -1;
    if (req0_valid && req1_valid) return m_prio;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prio <= 0; m_we <= 1'b0; m_addr <= '0; m_data <= '0; m_id <= 0; m_cnt <= 0;
    end else begin
      m_we <= (model_grant() != -1);
      if (model_grant() == 0) begin
        m_addr <= req0_addr; m_data <= req0_data; m_id <= 0; m_prio <= 1;
      end else if (model_grant() == 1) begin
        m_addr <= req1_addr; m_data <= req1_data; m_id <= 1; m_prio <= 0;
      end
      if (req0_valid && req1_valid && !stall) m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("ready0", 32'(req0_ready), 32'(model_grant() == 0));
    check("ready1", 32'(req1_ready), 32'(model_grant() == 1));
    check("regwrite", 32'(RegWrite), 32'(m_we));
    check("write_addr", 32'(write_addr), 32'(m_addr));
    check("write_data", 32'(write_data), 32'(m_data));
    check("grant_id", 32'(grant_id), 32'(m_id));
    check("conflict_count", 32'(conflict_count), 32'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  logic t0, t1;
  bit   done;

  initial begin
    // Reset held with a pending request: nothing is accepted.
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 8'h07;
    tick(); tick();
    neg();
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    tick();
    reset = 1'b0;
    neg();
    check("single_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    neg();
    check("single_we", 32'(RegWrite), 32'd1);
    check("single_addr", 32'(write_addr), 32'd1);
    check("single_data", 32'(write_data), 32'h07);
    check("single_id", 32'(grant_id), 32'd0);
    tick();
    neg();
    check("single_rf1", 32'(rf[1]), 32'h07);

    // Fresh pointer, then contention between two different addresses.
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 8'h08;
    req1_valid = 1'b1; req1_addr = 3'd3; req1_data = 8'h09;
    neg();
    check("cont_ready0_first", 32'(req0_ready), 32'd1);
    check("cont_ready1_wait", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    neg();
    check("cont_ready1_second", 32'(req1_ready), 32'd1);
    check("cont_we_a", 32'(RegWrite), 32'd1);
    tick();
    req1_valid = 1'b0;
    neg();
    check("cont_we_b", 32'(RegWrite), 32'd1);
    check("cont_id_b", 32'(grant_id), 32'd1);
    check("cont_count", 32'(conflict_count), 32'd1);
    tick();
    neg();
    check("cont_rf2", 32'(rf[2]), 32'h08);
    check("cont_rf3", 32'(rf[3]), 32'h09);

    // Same address with the pointer on requester 1: later grant (req0) wins.
    req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 8'h55;
    tick();
    req0_addr = 3'd4; req0_data = 8'h0A;
    req1_valid = 1'b1; req1_addr = 3'd4; req1_data = 8'h0B;
    neg();
    check("same_ready1_first", 32'(req1_ready), 32'd1);
    check("same_ready0_wait", 32'(req0_ready), 32'd0);
    tick();
    req1_valid = 1'b0;
    neg();
    check("same_ready0_second", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    neg();
    check("same_rf4", 32'(rf[4]), 32'h0A);
    check("same_rf5", 32'(rf[5]), 32'h55);

    // Stall for three cycles with both valid.
    stall = 1'b1;
    req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 8'h66;
    req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      neg();
      check("stall_ready0", 32'(req0_ready), 32'd0);
      check("stall_ready1", 32'(req1_ready), 32'd0);
      check("stall_we", 32'(RegWrite), 32'd0);
      check("stall_count", 32'(conflict_count), 32'd2);
      tick();
    end
    stall = 1'b0;
    neg();
    check("resume_ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    neg();
    check("resume_ready0", 32'(req0_ready), 32'd1);
    check("resume_count", 32'(conflict_count), 32'd3);
    tick();
    req0_valid = 1'b0;

    // Randomized traffic: requesters hold until accepted; random stall/reset.
    for (int i = 0; i < 1500; i++) begin
      neg();
      t0 = req0_valid && req0_ready;
      t1 = req1_valid && req1_ready;
      tick();
      if (!req0_valid || t0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_addr  = 3'($urandom);
        req0_data  = 8'($urandom);
      end
      if (!req1_valid || t1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_addr  = 3'($urandom);
        req1_data  = 8'($urandom);
      end
      stall = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 199) == 0);
    end

    // Saturation: 300 contention cycles from a clean counter.
    reset = 1'b1; stall = 1'b0;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 8'hA1;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 8'hB2;
    for (int i = 0; i < 300; i++) tick();
    neg();
    check("sat_count", 32'(conflict_count), 32'd255);
    tick();
    check("sat_we_before_rst", 32'(RegWrite), 32'd1);

    // Reset in the middle of a transfer cycle clears everything at once.
    #2 reset = 1'b1;
    #1;
    check("midrst_we", 32'(RegWrite), 32'd0);
    check("midrst_addr", 32'(write_addr), 32'd0);
    check("midrst_data", 32'(write_data), 32'd0);
    check("midrst_id", 32'(grant_id), 32'd0);
    check("midrst_count", 32'(conflict_count), 32'd0);
    check("midrst_ready0", 32'(req0_ready), 32'd0);
    check("midrst_ready1", 32'(req1_ready), 32'd0);
    tick();
    reset = 1'b0;
    neg();
    check("post_rst_ready0", 32'(req0_ready), 32'd1);
    check("post_rst_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    if (!done) begin
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
    end
  end

endmodule
